// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and physical memory handshakes around mem_arbiter.
// slave is the arbiter's view; master is the view of the core and memory around it.
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic                  i_read;
   logic [ADDR_W-1:0]     i_address;
   logic [DATA_W-1:0]     i_rdata;
   logic                  i_resp;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_W-1:0]     d_address;
   logic [DATA_W-1:0]     d_wdata;
   logic [DATA_W/8-1:0]   d_byte_enable;
   logic [DATA_W-1:0]     d_rdata;
   logic                  d_resp;

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_W-1:0]     pmem_address;
   logic [DATA_W-1:0]     pmem_wdata;
   logic [DATA_W/8-1:0]   pmem_byte_enable;
   logic [DATA_W-1:0]     pmem_rdata;
   logic                  pmem_resp;

   modport slave (
      input  i_read, i_address,
      input  d_read, d_write, d_address, d_wdata, d_byte_enable,
      input  pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
   );

   modport master (
      output i_read, i_address,
      output d_read, d_write, d_address, d_wdata, d_byte_enable,
      output pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one physical memory port between LC-3b fetch (I) and data (D) requests.
// Define MEM_ARBITER_ROUND_ROBIN_EN for alternating grants on ties; default is D-over-I.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input logic         clk,
   input logic         rst_n,
   mem_arbiter_if.slave bus
);
   localparam int MASK_W = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                cmd_read;
   logic                cmd_write;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [MASK_W-1:0]   cmd_mask;
   logic                d_req;
   logic                grant_d;
   logic                grant_i;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   logic                last_grant_d;
`endif

   always_comb begin
      d_req = bus.d_read | bus.d_write;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      // On a tie, hand the port to whoever did not have it last.
      grant_d = d_req && !(bus.i_read && last_grant_d);
`else
      grant_d = d_req;
`endif
      grant_i = bus.i_read && !grant_d;
   end

   always_comb begin
      state_nxt       = state;
      bus.i_resp      = 1'b0;
      bus.d_resp      = 1'b0;
      bus.pmem_read   = 1'b0;
      bus.pmem_write  = 1'b0;
      case (state)
         IDLE: begin
            if (grant_d)
               state_nxt = GRANT_D;
            else if (grant_i)
               state_nxt = GRANT_I;
         end
         GRANT_I: begin
            bus.pmem_read  = cmd_read;
            bus.pmem_write = cmd_write;
            if (bus.pmem_resp) begin
               bus.i_resp = 1'b1;
               state_nxt  = DONE;
            end
         end
         GRANT_D: begin
            bus.pmem_read  = cmd_read;
            bus.pmem_write = cmd_write;
            if (bus.pmem_resp) begin
               bus.d_resp = 1'b1;
               state_nxt  = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Command is captured once in IDLE so requester changes mid-grant never reach memory.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_read  <= 1'b0;
         cmd_write <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_mask  <= '0;
      end else if (state == IDLE) begin
         if (grant_d) begin
            cmd_read  <= bus.d_read & ~bus.d_write;
            cmd_write <= bus.d_write;
            cmd_addr  <= bus.d_address;
            cmd_wdata <= bus.d_wdata;
            cmd_mask  <= bus.d_byte_enable;
         end else if (grant_i) begin
            cmd_read  <= 1'b1;
            cmd_write <= 1'b0;
            cmd_addr  <= bus.i_address;
            cmd_wdata <= '0;
            cmd_mask  <= '1;
         end
      end
   end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         last_grant_d <= 1'b1;
      else if (state == IDLE && (grant_d || grant_i))
         last_grant_d <= grant_d;
   end
`endif

   assign bus.pmem_address     = cmd_addr;
   assign bus.pmem_wdata       = cmd_wdata;
   assign bus.pmem_byte_enable = cmd_mask;
   assign bus.i_rdata          = bus.pmem_rdata;
   assign bus.d_rdata          = bus.pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level model plus per-cycle output compare.
module tb_mem_arbiter;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int MASK_W = DATA_W / 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   int cycle  = 0;
   int i_cnt  = 0;
   int d_cnt  = 0;
   bit order[$];
   int resp_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Model: one outstanding transaction record, then one dead cycle after its completion.
   bit                m_valid = 0;
   bit                m_busy  = 0;
   bit                m_dead  = 0;
   bit                m_own_d = 0;
   bit                m_last_d = 1;
   bit                m_rd, m_wr;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [MASK_W-1:0] m_mask;

   always @(posedge clk) begin
      bit dq, take_d;
      cycle++;
      dq = bus.d_read | bus.d_write;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      take_d = dq && !(bus.i_read && m_last_d);
`else
      take_d = dq;
`endif
      if (!rst_n) begin
         m_valid = 1; m_busy = 0; m_dead = 0; m_last_d = 1;
      end else if (m_dead) begin
         m_dead = 0;
      end else if (m_busy) begin
         if (bus.pmem_resp) begin m_busy = 0; m_dead = 1; end
      end else if (take_d) begin
         m_busy = 1; m_own_d = 1; m_last_d = 1;
         m_rd = bus.d_read && !bus.d_write; m_wr = bus.d_write;
         m_addr = bus.d_address; m_wdata = bus.d_wdata; m_mask = bus.d_byte_enable;
      end else if (bus.i_read) begin
         m_busy = 1; m_own_d = 0; m_last_d = 0;
         m_rd = 1; m_wr = 0; m_addr = bus.i_address; m_mask = '1;
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("pmem_read",  bus.pmem_read,  m_busy & m_rd);
         check("pmem_write", bus.pmem_write, m_busy & m_wr);
         check("i_resp", bus.i_resp, m_busy & !m_own_d & bus.pmem_resp);
         check("d_resp", bus.d_resp, m_busy &  m_own_d & bus.pmem_resp);
         check("i_rdata", bus.i_rdata, bus.pmem_rdata);
         check("d_rdata", bus.d_rdata, bus.pmem_rdata);
         if (m_busy) begin
            check("pmem_address", bus.pmem_address, m_addr);
            check("pmem_byte_enable", bus.pmem_byte_enable, m_mask);
            if (m_wr) check("pmem_wdata", bus.pmem_wdata, m_wdata);
         end
         if (bus.i_resp) begin i_cnt++; order.push_back(1'b0); resp_cyc.push_back(cycle); end
         if (bus.d_resp) begin d_cnt++; order.push_back(1'b1); resp_cyc.push_back(cycle); end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a strobe, then complete it after 'delay' more cycles.
   task automatic serve(input int delay, input logic [DATA_W-1:0] rdata);
      int n;
      n = 0;
      while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
         tick();
         n++;
      end
      check("grant_wait", (n < 20), 1);
      repeat (delay) tick();
      bus.pmem_rdata = rdata;
      bus.pmem_resp  = 1'b1;
      tick();
      bus.pmem_resp  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      bit exp_ord[4];
      int ci, cd;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_ord = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
      rst_n = 1'b0;
      bus.i_read = 0; bus.i_address = '0;
      bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0; bus.d_byte_enable = '0;
      bus.pmem_rdata = '0; bus.pmem_resp = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_pmem_address", bus.pmem_address, 16'h0000);
      check("rst_pmem_wdata", bus.pmem_wdata, 16'h0000);
      check("rst_pmem_byte_enable", bus.pmem_byte_enable, 2'b00);
      check("rst_strobes", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0000);

      // Fetch read, memory answers in the third grant cycle
      tick();
      bus.i_read = 1; bus.i_address = 16'h0100;
      tick();
      @(negedge clk);
      check("t1_read", {bus.pmem_read, bus.pmem_write}, 2'b10);
      check("t1_addr", bus.pmem_address, 16'h0100);
      tick(); tick();
      bus.pmem_rdata = 16'h1234; bus.pmem_resp = 1;
      @(negedge clk);
      check("t1_i_resp", {bus.i_resp, bus.d_resp}, 2'b10);
      check("t1_i_rdata", bus.i_rdata, 16'h1234);
      tick();
      bus.pmem_resp = 0; bus.i_read = 0;
      @(negedge clk);
      check("t1_done_quiet", {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, 4'b0000);
      tick();
      check("t1_i_count", i_cnt, 1);

      // Data write with the address changing mid-grant
      bus.d_write = 1; bus.d_address = 16'h2001; bus.d_wdata = 16'h00AB; bus.d_byte_enable = 2'b10;
      tick();
      bus.d_address = 16'h3000;
      @(negedge clk);
      check("t2_write", {bus.pmem_read, bus.pmem_write}, 2'b01);
      check("t2_addr", bus.pmem_address, 16'h2001);
      check("t2_mask", bus.pmem_byte_enable, 2'b10);
      check("t2_wdata", bus.pmem_wdata, 16'h00AB);
      tick();
      @(negedge clk);
      check("t2_addr_held", bus.pmem_address, 16'h2001);
      tick();
      bus.pmem_resp = 1;
      @(negedge clk);
      check("t2_d_resp", {bus.i_resp, bus.d_resp}, 2'b01);
      tick();
      bus.pmem_resp = 0; bus.d_write = 0;
      tick();
      check("t2_d_count", d_cnt, 1);

      // Two simultaneous I/D pairs
      for (int p = 0; p < 2; p++) begin
         bus.i_read = 1; bus.i_address = 16'h0200 + 16'(p);
         bus.d_read = 1; bus.d_address = 16'h0300 + 16'(p);
         for (int k = 0; k < 2; k++) begin
            serve(1, 16'hA000 + 16'(2 * p + k));
            if (order.size() > 0 && order[order.size()-1]) bus.d_read = 0;
            else bus.i_read = 0;
         end
      end
      bus.i_read = 0; bus.d_read = 0;
      tick(); tick();
      check("t3_order_len", order.size(), 6);
      if (order.size() == 6) begin
         for (int k = 0; k < 4; k++) check("t3_grant_order", order[2 + k], exp_ord[k]);
         check("t3_spacing_ge4", (resp_cyc[3] - resp_cyc[2] >= 4), 1);
      end

      // Reset in the middle of a pending D grant, then a stray pmem_resp
      bus.d_read = 1; bus.d_address = 16'h4000;
      tick();
      @(negedge clk);
      check("t4_granted", bus.pmem_read, 1'b1);
      tick();
      rst_n = 0; bus.d_read = 0;
      tick();
      rst_n = 1;
      @(negedge clk);
      check("t4_rst_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
      check("t4_rst_addr", bus.pmem_address, 16'h0000);
      ci = i_cnt; cd = d_cnt;
      tick();
      bus.pmem_resp = 1;
      tick();
      bus.pmem_resp = 0;
      tick();
      check("t4_no_late_resp", i_cnt + d_cnt, ci + cd);

      // Read and write together: write wins for the whole grant
      bus.d_read = 1; bus.d_write = 1; bus.d_address = 16'h5000;
      bus.d_wdata = 16'h5555; bus.d_byte_enable = 2'b01;
      tick();
      @(negedge clk);
      check("t5_write_wins", {bus.pmem_read, bus.pmem_write}, 2'b01);
      serve(2, 16'h0000);
      bus.d_read = 0; bus.d_write = 0;
      tick(); tick();
      check("final_i_count", i_cnt, 3);
      check("final_d_count", d_cnt, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
